// File: rtl/attr_table_writer.sv
// Sprite attribute table write front end: entry FIFO, double-buffered bank swap on vsync, bank clearing.
// Optional macro ATTR_BLANK_GATE_EN restricts RAM writes to blanking (visible=0).
module attr_table_writer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_index,
    input  logic [11:0] in_x,
    input  logic [10:0] in_y,
    input  logic [7:0]  in_pattern,
    input  logic        commit,
    input  logic        vsync,
    input  logic        visible,
    output logic        wr_en,
    output logic [6:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        rd_bank,
    output logic        commit_pending,
    output logic        busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 37;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {INIT_CLR, IDLE, FLUSH, WAIT_VS, CLR} state_t;

    state_t         state, next_state;
    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic [6:0]     clr_cnt;
    logic           vsync_q;
    logic           fifo_full, push, pop, commit_acc, vs_rise;
    logic           clr_step, clr_last, wr_allow;
    logic [EW-1:0]  head;

`ifdef ATTR_BLANK_GATE_EN
    assign wr_allow = !visible;
`else
    logic unused_visible;
    assign unused_visible = visible;
    assign wr_allow = 1'b1;
`endif

    assign fifo_full = (fifo_count == DEPTH_CNT);
    assign in_ready  = (state == IDLE) && !fifo_full;
    assign head      = fifo_mem[rd_ptr];

    always_comb begin
        push       = in_valid && in_ready;
        pop        = ((state == IDLE) || (state == FLUSH)) && (fifo_count != '0) && wr_allow;
        commit_acc = commit && (state == IDLE) && !commit_pending;
        vs_rise    = vsync && !vsync_q;
        clr_step   = ((state == INIT_CLR) || (state == CLR)) && wr_allow;
        clr_last   = (state == INIT_CLR) ? (clr_cnt == 7'd127) : (clr_cnt == 7'd63);
        next_state = state;
        case (state)
            INIT_CLR: if (clr_step && clr_last) next_state = IDLE;
            IDLE:     if (commit_acc) next_state = FLUSH;
            FLUSH:    if (fifo_count == '0) next_state = WAIT_VS;
            WAIT_VS:  if (vs_rise) next_state = CLR;
            CLR:      if (clr_step && clr_last) next_state = IDLE;
            default:  next_state = INIT_CLR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= INIT_CLR;
        else       state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {in_index, in_pattern, in_y, in_x};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            clr_cnt        <= '0;
            vsync_q        <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            rd_bank        <= 1'b0;
            commit_pending <= 1'b0;
            busy           <= 1'b1;
        end else begin
            vsync_q <= vsync;
            busy    <= (next_state != IDLE);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (clr_step) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            wr_en <= pop || clr_step;
            if (pop) begin
                wr_addr <= {~rd_bank, head[36:31]};
                wr_data <= {1'b1, head[30:0]};
            end else if (clr_step) begin
                wr_addr <= (state == INIT_CLR) ? clr_cnt : {~rd_bank, clr_cnt[5:0]};
                wr_data <= '0;
            end
            // The toggled rd_bank makes ~rd_bank the freshly retired bank for CLR.
            if ((state == WAIT_VS) && vs_rise) begin
                rd_bank        <= ~rd_bank;
                commit_pending <= 1'b0;
            end else if (commit_acc) begin
                commit_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_attr_table_writer.sv
// Directed self-checking bench for attr_table_writer; write traffic is captured into a queue.
module tb_attr_table_writer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_index = '0;
    logic [11:0] in_x = '0;
    logic [10:0] in_y = '0;
    logic [7:0]  in_pattern = '0;
    logic        commit = 1'b0;
    logic        vsync = 1'b0;
    logic        visible = 1'b0;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_bank;
    logic        commit_pending;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [38:0] wq[$];

    attr_table_writer #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_index(in_index), .in_x(in_x), .in_y(in_y), .in_pattern(in_pattern),
        .commit(commit), .vsync(vsync), .visible(visible), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
        .commit_pending(commit_pending), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    function automatic int pop_clear_bad(input int n, input logic [6:0] base);
        int bad = 0;
        logic [38:0] e;
        for (int i = 0; i < n; i++) begin
            if (wq.size() == 0) begin bad++; continue; end
            e = wq.pop_front();
            if (e !== {base + 7'(i), 32'h0}) bad++;
        end
        return bad;
    endfunction

    function automatic logic [38:0] b2b_exp(input int k);
        logic [5:0]  idx = 6'(10 + k);
        logic [11:0] x   = 12'(200 + 7 * k);
        logic [10:0] y   = 11'(300 + k);
        logic [7:0]  pat = 8'(17 * k + 1);
        return {1'b1, idx, 1'b1, pat, y, x};
    endfunction

    task automatic set_b2b(input int k);
        in_index   = 6'(10 + k);
        in_x       = 12'(200 + 7 * k);
        in_y       = 11'(300 + k);
        in_pattern = 8'(17 * k + 1);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 7'h0) begin errors++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL rst_rd_bank got=%b exp=0", rd_bank); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL rst_commit_pending got=%b exp=0", commit_pending); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    endtask

    task automatic test_init_clear;
        bit ok;
        int bad, n;
        wq.delete();
        @(posedge clock); #1 reset = 1'b0;
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_timeout got=%b exp=1", ok); end
        n = wq.size();
        checks++; if (n !== 128) begin errors++; $display("FAIL init_count got=%0d exp=128", n); end
        bad = pop_clear_bad(128, 7'd0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_seq bad=%0d exp=0", bad); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL init_in_ready got=%b exp=1", in_ready); end
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL init_rd_bank got=%b exp=0", rd_bank); end
    endtask

    task automatic test_single_write;
        wq.delete();
        in_index = 6'd5; in_x = 12'd100; in_y = 11'd50; in_pattern = 8'h03; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", wr_en); end
        tick();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
        checks++; if (wr_addr !== 7'h45) begin errors++; $display("FAIL single_addr got=%h exp=45", wr_addr); end
        checks++; if (wr_data !== {1'b1, 8'h03, 11'd50, 12'd100}) begin
            errors++; $display("FAIL single_data got=%h exp=%h", wr_data, {1'b1, 8'h03, 11'd50, 12'd100});
        end
        repeat (3) tick();
        wq.delete();
    endtask

    task automatic test_back_to_back;
        int accepted = 0;
        int stall_info = -1;
        int bad = 0;
        int n;
        bit rdy;
        logic [38:0] e;
        wq.delete();
`ifdef ATTR_BLANK_GATE_EN
        visible = 1'b1;
`endif
        set_b2b(0);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && accepted < 6; cyc++) begin
            @(negedge clock);
            rdy = in_ready;
`ifdef ATTR_BLANK_GATE_EN
            if (!rdy && stall_info < 0) stall_info = accepted;
            if (cyc == 12) visible = 1'b0;
`else
            if (!rdy) stall_info = accepted;
`endif
            @(posedge clock); #1;
            if (rdy) begin
                accepted++;
                if (accepted < 6) set_b2b(accepted);
            end
        end
        in_valid = 1'b0;
        visible  = 1'b0;
        repeat (8) tick();
        checks++; if (accepted !== 6) begin errors++; $display("FAIL b2b_accepted got=%0d exp=6", accepted); end
`ifdef ATTR_BLANK_GATE_EN
        checks++; if (stall_info !== 4) begin errors++; $display("FAIL b2b_stall_after got=%0d exp=4", stall_info); end
`else
        checks++; if (stall_info !== -1) begin errors++; $display("FAIL b2b_no_stall got=%0d exp=-1", stall_info); end
`endif
        n = wq.size();
        checks++; if (n !== 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", n); end
        for (int k = 0; k < 6; k++) begin
            if (wq.size() == 0) begin bad++; continue; end
            e = wq.pop_front();
            if (e !== b2b_exp(k)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_order bad=%0d exp=0", bad); end
    endtask

    task automatic test_commit_swap;
        bit ok;
        int bad, n;
        logic [38:0] e;
        wq.delete();
        vsync = 1'b0;
        in_index = 6'd20; in_x = 12'd1; in_y = 11'd2; in_pattern = 8'hAA;
        in_valid = 1'b1; commit = 1'b1;
        tick();
        in_valid = 1'b0; commit = 1'b0;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL cs_pending got=%b exp=1", commit_pending); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cs_busy got=%b exp=1", busy); end
        repeat (10) tick();
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL cs_no_swap got=%b exp=0", rd_bank); end
        n = wq.size();
        checks++; if (n !== 1) begin errors++; $display("FAIL cs_entry_count got=%0d exp=1", n); end
        if (n > 0) begin
            e = wq.pop_front();
            checks++; if (e !== {1'b1, 6'd20, 1'b1, 8'hAA, 11'd2, 12'd1}) begin
                errors++; $display("FAIL cs_entry got=%h exp=%h", e, {1'b1, 6'd20, 1'b1, 8'hAA, 11'd2, 12'd1});
            end
        end
        vsync = 1'b1;
        tick();
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL cs_swap got=%b exp=1", rd_bank); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL cs_pending_clr got=%b exp=0", commit_pending); end
        wait_idle(200, ok);
        vsync = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cs_clr_timeout got=%b exp=1", ok); end
        n = wq.size();
        checks++; if (n !== 64) begin errors++; $display("FAIL cs_clr_count got=%0d exp=64", n); end
        bad = pop_clear_bad(64, 7'd0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL cs_clr_seq bad=%0d exp=0", bad); end
    endtask

    task automatic test_vsync_held;
        bit ok;
        int bad, n;
        wq.delete();
        vsync = 1'b1;
        repeat (3) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (10) tick();
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL vh_held_no_swap got=%b exp=1", rd_bank); end
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL vh_pending got=%b exp=1", commit_pending); end
        vsync = 1'b0;
        repeat (3) tick();
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL vh_low_no_swap got=%b exp=1", rd_bank); end
        vsync = 1'b1;
        tick();
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL vh_swap got=%b exp=0", rd_bank); end
        wait_idle(200, ok);
        vsync = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL vh_clr_timeout got=%b exp=1", ok); end
        n = wq.size();
        checks++; if (n !== 64) begin errors++; $display("FAIL vh_clr_count got=%0d exp=64", n); end
        bad = pop_clear_bad(64, 7'd64);
        checks++; if (bad !== 0) begin errors++; $display("FAIL vh_clr_seq bad=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_clr;
        bit ok;
        int bad, n;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        tick();
        wq.delete();
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL rm_swap got=%b exp=1", rd_bank); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (wq.size() >= 30) break;
        end
        n = wq.size();
        checks++; if (n !== 30) begin errors++; $display("FAIL rm_partial_count got=%0d exp=30", n); end
        reset = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 7'h0) begin errors++; $display("FAIL rm_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL rm_rd_bank got=%b exp=0", rd_bank); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy got=%b exp=1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready got=%b exp=0", in_ready); end
        bad = pop_clear_bad(30, 7'd0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL rm_partial_seq bad=%0d exp=0", bad); end
        vsync = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        wq.delete();
        reset = 1'b0;
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_init_timeout got=%b exp=1", ok); end
        n = wq.size();
        checks++; if (n !== 128) begin errors++; $display("FAIL rm_init_count got=%0d exp=128", n); end
        bad = pop_clear_bad(128, 7'd0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL rm_init_seq bad=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_single_write();
        test_back_to_back();
        test_commit_swap();
        test_vsync_held();
        test_reset_mid_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/attr_table_writer.md
# attr_table_writer

Write-side front end of the sprite attribute table: accepts per-sprite attribute entries from the game state machine over a valid/ready bus and writes them into the back bank of a double-buffered 2×64-entry attribute RAM, which the ppu reads from. On a commit request the banks swap at the next vsync, so the ppu never renders a half-updated table. After every swap the new back bank is cleared, leaving all sprites disabled.

## Interface
- FIFO_DEPTH, 4: entry FIFO depth, power of two, ≥2.
- clock  in  1  system/pixel clock, all logic on posedge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  entry offered.
- in_ready  out  1  entry accepted when in_valid && in_ready at posedge.
- in_index  in  6  sprite slot 0..63.
- in_x  in  12  sprite column.
- in_y  in  11  sprite row.
- in_pattern  in  8  pattern number in the sprite pattern memory.
- commit  in  1  single-cycle pulse, swap banks after the current entries are written.
- vsync  in  1  from vga_controller, active-high during the sync interval.
- visible  in  1  from vga_controller, high during the active area.
- wr_en  out  1  attribute RAM write strobe.
- wr_addr  out  7  {bank, index}.
- wr_data  out  32  {enable=1'b1, in_pattern, in_y, in_x}; MSB is enable.
- rd_bank  out  1  bank the ppu reads. Back bank = ~rd_bank.
- commit_pending  out  1  high from accepted commit until swap.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - INIT_CLR: entered from reset. Writes 128 words of 0, addr 0..127, then goes to IDLE.
  - IDLE: accepts entries and drains the FIFO. commit → FLUSH.
  - FLUSH: in_ready=0. Drains the FIFO; when empty → WAIT_VS.
  - WAIT_VS: on a vsync rising edge (vsync=1, registered previous sample=0), toggle rd_bank and clear commit_pending, then → CLR.
  - CLR: writes 64 words of 0 to {~rd_bank (new), 0..63}, then → IDLE.
- in_ready = (state==IDLE) && !fifo_full.
- Drain: one FIFO entry per cycle. wr_addr = {~rd_bank, index}.
- Push and pop in the same cycle are allowed; the FIFO count is unchanged.
- commit in the same cycle as an accepted entry: the entry is included in the swapped bank.
- commit while commit_pending=1 or state≠IDLE: ignored.
- A vsync edge in IDLE, FLUSH or CLR has no effect. A vsync edge already in progress when WAIT_VS is entered is not counted; only a fresh rising edge swaps.
- Duplicate in_index writes: last write wins.
- Clear counter is 7 bits. It wraps to 0 on exit, with no overflow past 127 (INIT_CLR) or 63 (CLR).

## Timing
- Reset values:
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, rd_bank=0, commit_pending=0, busy=1.
  - State INIT_CLR, FIFO empty.
- All outputs are registered except in_ready, which is combinational from state and FIFO count.
- Write latency: an entry accepted at edge N, with the FIFO empty and no gating, drives wr_en=1 in cycle N+1.
- commit_pending rises the cycle after the commit edge.
- Swap: rd_bank toggles on the edge at which vsync is first sampled 1 while in WAIT_VS. The first CLR write follows in the next cycle.
- INIT_CLR occupies ≥128 cycles; CLR occupies ≥64 cycles. Both are longer when write gating is enabled.
- Reset mid-operation:
  - FIFO, pending commit and counters are discarded.
  - rd_bank returns to 0 and INIT_CLR restarts.

## Configuration
- ATTR_BLANK_GATE_EN defined:
  - wr_en may assert only while visible=0, for RAM whose single port is shared with ppu reads.
  - FIFO drain and clear counters stall while visible=1.
  - in_ready still follows FIFO fullness.
- Undefined: visible is ignored and writes proceed every cycle.

## Test plan
- Reset release → 128 writes of 32'h0 at addr 0..127, then busy=0, in_ready=1, rd_bank=0.
- Push index=5, x=12'd100, y=11'd50, pattern=8'h3 → wr_en one cycle later, wr_addr=7'h45 (bank 1), wr_data={1'b1, 8'h03, 11'd50, 12'd100}.
- Push 6 entries with in_valid held and drain blocked (macro on, visible=1) → in_ready falls after 4. When visible falls, all 6 are written in order with no loss.
- commit in the same cycle as the last push → entry written, state enters WAIT_VS. No swap until the vsync rising edge; then rd_bank=1, commit_pending=0, and 64 zero writes to addr 0..63.
- vsync already high when WAIT_VS is entered → no swap until vsync falls and rises again.
- Assert reset during CLR at count 30 → outputs return to reset values and INIT_CLR restarts at addr 0.
